// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//   Multiplexed seven-segment driver. Scans NUM_DIGITS hex digits, one slot
//   per digit. Each slot is BLANK_CYCLES of all-anodes-off dead time followed
//   by REFRESH_DIV-BLANK_CYCLES cycles with that digit's anode on. The
//   displayed value is double-buffered and only changes at a frame boundary.
//
//   Optional feature: define SEVENSEG_LZB_EN for leading-zero blanking.
//   Digits above the most significant nonzero nibble are then treated as
//   disabled, and digit 0 is always shown.
//
// Ports
//   CLK          system clock
//   Reset        asynchronous, active-low reset
//   Value        hex nibbles, digit k = Value[4k+3:4k]
//   DigitEn      per-digit enable mask
//   Load         1-cycle strobe; captures Value/DigitEn into the pending buffer
//   SevenSegAn   anode drive, one-hot or all inactive
//   SevenSegCat  segments {g,f,e,d,c,b,a}
//   DigitIdx     index of the current slot
//   FrameDone    1-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYCLES   = 4,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int CAT_ACTIVE_LOW = 1,
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    Load,
  output logic [NUM_DIGITS-1:0]   SevenSegAn,
  output logic [6:0]              SevenSegCat,
  output logic [IDXW-1:0]         DigitIdx,
  output logic                    FrameDone
);

  localparam int CNTW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
  localparam logic [CNTW-1:0] ON_LAST    = CNTW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [6:0] CAT_OFF = (CAT_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  state_t                  state, state_nx;
  logic [CNTW-1:0]         cnt, cnt_nx;
  logic [IDXW-1:0]         digit_idx, idx_nx;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pending_value, active_value;
  logic [NUM_DIGITS-1:0]   pending_en, active_en;
  logic                    pending_valid;

  logic [NUM_DIGITS-1:0]   lzb_mask;
  logic [NUM_DIGITS-1:0]   shown_mask;
  logic                    lit;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   an_act, an_nx;
  logic [6:0]              seg, cat_nx;

  // Active-high hex decode, bit0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Slot sequencing: BLANK dead time, then ON, then advance to the next digit.
  // wrap marks the last ON cycle of the last digit, i.e. the frame boundary.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = digit_idx;
    wrap     = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = ST_ON;
          cnt_nx   = '0;
        end
      end
      default: begin
        if (cnt == ON_LAST) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
          if (digit_idx == IDX_LAST) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = digit_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_BLANK;
      cnt       <= '0;
      digit_idx <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      digit_idx <= idx_nx;
    end
  end

  // Double buffer. A Load landing on the wrap cycle bypasses pending so the
  // new value appears from slot 0 of the frame that is just starting.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending_value <= '0;
      pending_en    <= '0;
      pending_valid <= 1'b0;
      active_value  <= '0;
      active_en     <= '0;
    end else if (wrap) begin
      if (Load) begin
        active_value <= Value;
        active_en    <= DigitEn;
      end else if (pending_valid) begin
        active_value <= pending_value;
        active_en    <= pending_en;
      end
      pending_valid <= 1'b0;
    end else if (Load) begin
      pending_value <= Value;
      pending_en    <= DigitEn;
      pending_valid <= 1'b1;
    end
  end

`ifdef SEVENSEG_LZB_EN
  // Keep digit k only if some nibble at position >= k is nonzero; digit 0
  // is always kept so a zero value still shows a single "0".
  always_comb begin
    logic seen;
    seen     = 1'b0;
    lzb_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      seen        = seen | (active_value[4*k +: 4] != 4'h0);
      lzb_mask[k] = seen | (k == 0);
    end
  end
`else
  assign lzb_mask = {NUM_DIGITS{1'b1}};
`endif

  assign shown_mask = active_en & lzb_mask;

  // Output decode from the current state; registered below, so the pins
  // lag the state register by one cycle.
  always_comb begin
    lit    = (state == ST_ON) && shown_mask[digit_idx];
    nibble = active_value[4*digit_idx +: 4];
    an_act = '0;
    if (lit) begin
      an_act[digit_idx] = 1'b1;
    end
    seg    = lit ? hex_to_seg(nibble) : 7'h00;
    an_nx  = (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
    cat_nx = (CAT_ACTIVE_LOW != 0) ? ~seg : seg;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      SevenSegAn  <= AN_OFF;
      SevenSegCat <= CAT_OFF;
      FrameDone   <= 1'b0;
    end else begin
      SevenSegAn  <= an_nx;
      SevenSegCat <= cat_nx;
      FrameDone   <= wrap;
    end
  end

  assign DigitIdx = digit_idx;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Directed bench for sevenseg_scan_driver with NUM_DIGITS=4, REFRESH_DIV=10,
//   BLANK_CYCLES=2, active-low anodes and cathodes. Frames are 40 cycles:
//   per slot 2 dark cycles then 8 lit cycles (as seen on the registered pins).
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

  logic        CLK;
  logic        Reset;
  logic [15:0] Value;
  logic [3:0]  DigitEn;
  logic        Load;
  logic [3:0]  SevenSegAn;
  logic [6:0]  SevenSegCat;
  logic [1:0]  DigitIdx;
  logic        FrameDone;

  int compared   = 0;
  int mismatched = 0;

  // Active-low cathode patterns, packed {digit3, digit2, digit1, digit0}.
  localparam logic [27:0] CATS_8F05 = {7'h00, 7'h0E, 7'h40, 7'h12};
  localparam logic [27:0] CATS_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] CATS_0030 = {7'h40, 7'h40, 7'h30, 7'h40};
  localparam logic [27:0] CATS_0000 = {7'h40, 7'h40, 7'h40, 7'h40};

`ifdef SEVENSEG_LZB_EN
  localparam logic [3:0] LZB_0030 = 4'b0011;
  localparam logic [3:0] LZB_0000 = 4'b0001;
`else
  localparam logic [3:0] LZB_0030 = 4'b1111;
  localparam logic [3:0] LZB_0000 = 4'b1111;
`endif

  sevenseg_scan_driver #(
    .NUM_DIGITS    (4),
    .REFRESH_DIV   (10),
    .BLANK_CYCLES  (2),
    .AN_ACTIVE_LOW (1),
    .CAT_ACTIVE_LOW(1)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Value      (Value),
    .DigitEn    (DigitEn),
    .Load       (Load),
    .SevenSegAn (SevenSegAn),
    .SevenSegCat(SevenSegCat),
    .DigitIdx   (DigitIdx),
    .FrameDone  (FrameDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] en);
    Value   = v;
    DigitEn = en;
    Load    = 1'b1;
  endtask

  // Advance to the sample point where FrameDone is high, bounded.
  task automatic waitFrame();
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (FrameDone) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput("frame_timeout", {31'd0, FrameDone}, 32'd1);
  endtask

  // Starting at a FrameDone sample, check all 40 cycles of the next frame.
  // ld1/ld2 give the cycle offsets at which a Load pulse is captured.
  task automatic runFrame(input string tag, input logic [27:0] cats, input logic [3:0] en,
                          input int ld1, input logic [15:0] v1, input logic [3:0] e1,
                          input int ld2, input logic [15:0] v2, input logic [3:0] e2);
    int k, r;
    bit on;
    logic [3:0] expAn;
    logic [6:0] expCat;
    for (int o = 1; o <= 40; o++) begin
      if (o == ld1) applyStimulus(v1, e1);
      else if (o == ld2) applyStimulus(v2, e2);
      @(negedge CLK);
      Load   = 1'b0;
      k      = (o - 1) / 10;
      r      = (o - 1) % 10;
      on     = (r >= 2) && en[k];
      expAn  = on ? ~(4'b0001 << k) : 4'hF;
      expCat = on ? cats[7*k +: 7] : 7'h7F;
      checkOutput($sformatf("%s an o=%0d", tag, o), {28'd0, SevenSegAn}, {28'd0, expAn});
      checkOutput($sformatf("%s cat o=%0d", tag, o), {25'd0, SevenSegCat}, {25'd0, expCat});
      checkOutput($sformatf("%s idx o=%0d", tag, o), {30'd0, DigitIdx}, 32'((o % 40) / 10));
      checkOutput($sformatf("%s fd o=%0d", tag, o), {31'd0, FrameDone}, {31'd0, o == 40});
    end
  endtask

  initial begin
    Reset   = 1'b0;
    Value   = 16'h0;
    DigitEn = 4'h0;
    Load    = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset an", {28'd0, SevenSegAn}, 32'hF);
    checkOutput("reset cat", {25'd0, SevenSegCat}, 32'h7F);
    checkOutput("reset idx", {30'd0, DigitIdx}, 32'd0);
    checkOutput("reset fd", {31'd0, FrameDone}, 32'd0);

    // First slot after release: 2 blank + 8 on cycles of state, then idx 1.
    Reset = 1'b1;
    @(negedge CLK);
    checkOutput("release an", {28'd0, SevenSegAn}, 32'hF);
    repeat (8) @(negedge CLK);
    checkOutput("slot0 last idx", {30'd0, DigitIdx}, 32'd0);
    @(negedge CLK);
    checkOutput("slot1 first idx", {30'd0, DigitIdx}, 32'd1);

    applyStimulus(16'h8F05, 4'hF);
    @(negedge CLK);
    Load = 1'b0;
    waitFrame();
    runFrame("f8F05a", CATS_8F05, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("f8F05b", CATS_8F05, 4'hF, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    runFrame("hold", CATS_8F05, 4'hF, 15, 16'h1234, 4'hF, 0, 16'h0, 4'h0);
    runFrame("f1234", CATS_1234, 4'hF, 40, 16'h8F05, 4'hF, 0, 16'h0, 4'h0);
    runFrame("wrapld", CATS_8F05, 4'hF, 5, 16'h0030, 4'hF, 20, 16'h0030, 4'b0101);
    runFrame("en0101", CATS_0030, 4'b0101 & LZB_0030, 10, 16'h0030, 4'hF, 0, 16'h0, 4'h0);
    runFrame("v0030", CATS_0030, LZB_0030, 40, 16'h0000, 4'hF, 0, 16'h0, 4'h0);
    runFrame("v0000", CATS_0000, LZB_0000, 25, 16'hABCD, 4'hF, 0, 16'h0, 4'h0);

    // Asynchronous reset in the middle of digit 0's ON time.
    repeat (5) @(negedge CLK);
    checkOutput("preRst an", {28'd0, SevenSegAn}, 32'hE);
    #2 Reset = 1'b0;
    #1;
    checkOutput("midRst an", {28'd0, SevenSegAn}, 32'hF);
    checkOutput("midRst cat", {25'd0, SevenSegCat}, 32'h7F);
    checkOutput("midRst idx", {30'd0, DigitIdx}, 32'd0);
    checkOutput("midRst fd", {31'd0, FrameDone}, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    waitFrame();
    runFrame("postRst", CATS_0000, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
